// File: rtl/exc_ctrl.sv
// Exception/ERTN sequencer at commit: arbitrates interrupt/exception/ERTN/commit, owns CRMD/PRMD/ERA/ESTAT.
// Latency: record pulse 1 cycle after accept; flush next cycle, redirect after that; at least 3 cycles back to IDLE.
// Backpressure: wb_ready low outside IDLE; redirect held until redirect_ready. Optional EXC_CTRL_PERF_EN adds counters.
module exc_ctrl #(
   parameter logic [31:0] ERA_RESET = 32'h0,
   parameter int          NUM_INT   = 13
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               wb_valid,
   output logic               wb_ready,
   input  logic [31:0]        wb_pc,
   input  logic [31:0]        wb_inst,
   input  logic               wb_ex,
   input  logic [5:0]         wb_ecode,
   input  logic [8:0]         wb_esubcode,
   input  logic               wb_ertn,
   input  logic [NUM_INT-1:0] int_pend,
   input  logic [NUM_INT-1:0] int_mask,
   input  logic [31:0]        eentry,
   input  logic               csr_we,
   input  logic [1:0]         csr_sel,
   input  logic [31:0]        csr_wdata,
   output logic [1:0]         crmd_plv,
   output logic               crmd_ie,
   output logic [1:0]         prmd_pplv,
   output logic               prmd_pie,
   output logic [31:0]        era_out,
   output logic [5:0]         estat_ecode,
   output logic [8:0]         estat_esubcode,
   output logic               flush,
   output logic               redirect_valid,
   output logic [31:0]        redirect_pc,
   input  logic               redirect_ready,
   output logic               rec_valid,
   output logic [31:0]        rec_inst,
   output logic [31:0]        rec_pc,
   output logic               rec_ex,
   output logic               rec_ertn,
   output logic [5:0]         rec_ecode,
   output logic [8:0]         rec_esubcode
`ifdef EXC_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_ex_cnt,
   output logic [31:0]        perf_ertn_cnt
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REDIRECT = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [31:0] target;
   logic        accept, int_take, take_ex, take_ertn, csr_apply;
   logic [5:0]  ex_ecode;
   logic [8:0]  ex_esubcode;

   // Decision for the retiring instruction; interrupts override its own exception codes.
   always_comb begin
      accept      = wb_valid & (state == IDLE);
      int_take    = crmd_ie & (|(int_pend & int_mask));
      take_ex     = accept & (int_take | wb_ex);
      take_ertn   = accept & ~int_take & ~wb_ex & wb_ertn;
      csr_apply   = csr_we & (state == IDLE) & ~take_ex & ~take_ertn;
      ex_ecode    = int_take ? 6'd0 : wb_ecode;
      ex_esubcode = int_take ? 9'd0 : wb_esubcode;
   end

   // Next-state: accept of exception/ERTN walks FLUSH -> REDIRECT -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (take_ex | take_ertn) state_nxt = FLUSH;
         FLUSH:    state_nxt = REDIRECT;
         REDIRECT: if (redirect_ready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Ready is held low while reset is asserted so every output reads zero in reset.
   assign wb_ready       = resetn & (state == IDLE);
   assign flush          = (state == FLUSH);
   assign redirect_valid = (state == REDIRECT);
   assign redirect_pc    = target;

   // Architectural CSR state: exception/ERTN updates win over a same-cycle software write.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         crmd_plv       <= 2'd0;
         crmd_ie        <= 1'b0;
         prmd_pplv      <= 2'd0;
         prmd_pie       <= 1'b0;
         era_out        <= ERA_RESET;
         estat_ecode    <= 6'd0;
         estat_esubcode <= 9'd0;
         target         <= 32'd0;
      end else if (take_ex) begin
         prmd_pplv      <= crmd_plv;
         prmd_pie       <= crmd_ie;
         crmd_plv       <= 2'd0;
         crmd_ie        <= 1'b0;
         era_out        <= wb_pc;
         estat_ecode    <= ex_ecode;
         estat_esubcode <= ex_esubcode;
         target         <= {eentry[31:6], 6'b0};
      end else if (take_ertn) begin
         crmd_plv       <= prmd_pplv;
         crmd_ie        <= prmd_pie;
         target         <= era_out;
      end else if (csr_apply) begin
         case (csr_sel)
            2'd0: begin crmd_plv  <= csr_wdata[1:0]; crmd_ie  <= csr_wdata[2]; end
            2'd1: begin prmd_pplv <= csr_wdata[1:0]; prmd_pie <= csr_wdata[2]; end
            2'd2: era_out <= csr_wdata;
            default: ;
         endcase
      end
   end

   // Trace record: captured on the accept edge, valid for exactly one cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rec_valid    <= 1'b0;
         rec_inst     <= 32'd0;
         rec_pc       <= 32'd0;
         rec_ex       <= 1'b0;
         rec_ertn     <= 1'b0;
         rec_ecode    <= 6'd0;
         rec_esubcode <= 9'd0;
      end else begin
         rec_valid <= accept;
         if (accept) begin
            rec_inst     <= wb_inst;
            rec_pc       <= wb_pc;
            rec_ex       <= take_ex;
            rec_ertn     <= take_ertn;
            rec_ecode    <= take_ex ? ex_ecode : 6'd0;
            rec_esubcode <= take_ex ? ex_esubcode : 9'd0;
         end
      end
   end

`ifdef EXC_CTRL_PERF_EN
   // Event counters, wrapping naturally at 32 bits.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         perf_ex_cnt   <= 32'd0;
         perf_ertn_cnt <= 32'd0;
      end else begin
         if (take_ex)   perf_ex_cnt   <= perf_ex_cnt + 32'd1;
         if (take_ertn) perf_ertn_cnt <= perf_ertn_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: commit, syscall, ERTN, interrupt priority, CSR write collisions, reset mid-redirect.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants.
module tb_exc_ctrl;

   logic        clock = 1'b0;
   logic        resetn;
   logic        wb_valid, wb_ready;
   logic [31:0] wb_pc, wb_inst;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic        wb_ertn;
   logic [12:0] int_pend, int_mask;
   logic [31:0] eentry;
   logic        csr_we;
   logic [1:0]  csr_sel;
   logic [31:0] csr_wdata;
   logic [1:0]  crmd_plv, prmd_pplv;
   logic        crmd_ie, prmd_pie;
   logic [31:0] era_out;
   logic [5:0]  estat_ecode;
   logic [8:0]  estat_esubcode;
   logic        flush, redirect_valid, redirect_ready;
   logic [31:0] redirect_pc;
   logic        rec_valid, rec_ex, rec_ertn;
   logic [31:0] rec_inst, rec_pc;
   logic [5:0]  rec_ecode;
   logic [8:0]  rec_esubcode;
`ifdef EXC_CTRL_PERF_EN
   logic [31:0] perf_ex_cnt, perf_ertn_cnt;
`endif

   int nerr = 0;
   int nchk = 0;

   always #5 clock = ~clock;

   exc_ctrl #(.ERA_RESET(32'h0), .NUM_INT(13)) dut (
      .clock(clock), .resetn(resetn),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_inst(wb_inst),
      .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_ertn(wb_ertn),
      .int_pend(int_pend), .int_mask(int_mask), .eentry(eentry),
      .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
      .crmd_plv(crmd_plv), .crmd_ie(crmd_ie), .prmd_pplv(prmd_pplv), .prmd_pie(prmd_pie),
      .era_out(era_out), .estat_ecode(estat_ecode), .estat_esubcode(estat_esubcode),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready),
      .rec_valid(rec_valid), .rec_inst(rec_inst), .rec_pc(rec_pc), .rec_ex(rec_ex),
      .rec_ertn(rec_ertn), .rec_ecode(rec_ecode), .rec_esubcode(rec_esubcode)
`ifdef EXC_CTRL_PERF_EN
      , .perf_ex_cnt(perf_ex_cnt), .perf_ertn_cnt(perf_ertn_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clr_wb();
      wb_valid = 0; wb_ex = 0; wb_ertn = 0; wb_ecode = 0; wb_esubcode = 0;
      csr_we = 0;
   endtask

   initial begin
      resetn = 0; wb_valid = 0; wb_pc = 0; wb_inst = 0; wb_ex = 0; wb_ecode = 0;
      wb_esubcode = 0; wb_ertn = 0; int_pend = 0; int_mask = 0; eentry = 32'h1C000047;
      csr_we = 0; csr_sel = 0; csr_wdata = 0; redirect_ready = 0;
      #12;
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_flush", flush, 0);
      chk("rst_rdv", redirect_valid, 0);
      chk("rst_era", era_out, 32'h0);
      chk("rst_crmd", {crmd_ie, crmd_plv}, 0);
      resetn = 1;

      // Normal commit
      wb_valid = 1; wb_pc = 32'h80000000; wb_inst = 32'h02800413;
      step(); clr_wb();
      chk("cm_rec_valid", rec_valid, 1);
      chk("cm_rec_ex", rec_ex, 0);
      chk("cm_rec_pc", rec_pc, 32'h80000000);
      chk("cm_rec_inst", rec_inst, 32'h02800413);
      chk("cm_wb_ready", wb_ready, 1);
      chk("cm_flush", flush, 0);
      step();
      chk("cm_rec_drop", rec_valid, 0);
      chk("cm_flush2", flush, 0);

      // PLV=3, IE=1
      csr_we = 1; csr_sel = 0; csr_wdata = 32'h7;
      step(); clr_wb();
      chk("crmd_wr", {crmd_ie, crmd_plv}, 3'b111);

      // SYSCALL
      wb_valid = 1; wb_ex = 1; wb_ecode = 6'hB; wb_pc = 32'h80000010; wb_inst = 32'h002b0000;
      step(); clr_wb();
      chk("sc_era", era_out, 32'h80000010);
      chk("sc_prmd", {prmd_pie, prmd_pplv}, 3'b111);
      chk("sc_crmd", {crmd_ie, crmd_plv}, 0);
      chk("sc_rec", {rec_valid, rec_ex, rec_ertn}, 3'b110);
      chk("sc_rec_ecode", rec_ecode, 6'hB);
      chk("sc_estat", estat_ecode, 6'hB);
      chk("sc_flush", flush, 1);
      chk("sc_wb_ready", wb_ready, 0);
      step();
      chk("sc_flush_end", flush, 0);
      chk("sc_rdv", redirect_valid, 1);
      chk("sc_rdpc", redirect_pc, 32'h1C000040);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("sc_hold_rdv", redirect_valid, 1);
         chk("sc_hold_rdpc", redirect_pc, 32'h1C000040);
         chk("sc_hold_ready", wb_ready, 0);
      end
      redirect_ready = 1;
      step(); redirect_ready = 0;
      chk("sc_done_rdv", redirect_valid, 0);
      chk("sc_done_ready", wb_ready, 1);

      // ERTN
      wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1C000100; wb_inst = 32'h06483800;
      step(); clr_wb();
      chk("er_crmd", {crmd_ie, crmd_plv}, 3'b111);
      chk("er_rec", {rec_valid, rec_ex, rec_ertn}, 3'b101);
      chk("er_flush", flush, 1);
      step();
      chk("er_rdpc", redirect_pc, 32'h80000010);
      redirect_ready = 1;
      step(); redirect_ready = 0;
      chk("er_idle", wb_ready, 1);

      // Interrupt beats a same-cycle exception
      int_pend = 13'h800; int_mask = 13'h800;
      wb_valid = 1; wb_ex = 1; wb_ecode = 6'hD; wb_esubcode = 9'h3; wb_pc = 32'h80000200;
      step(); clr_wb(); int_pend = 0;
      chk("it_rec_ex", rec_ex, 1);
      chk("it_rec_ecode", rec_ecode, 0);
      chk("it_rec_esub", rec_esubcode, 0);
      chk("it_era", era_out, 32'h80000200);
      chk("it_estat", estat_ecode, 0);
      chk("it_prmd", {prmd_pie, prmd_pplv}, 3'b111);
      step();
      chk("it_rdpc", redirect_pc, 32'h1C000040);
      redirect_ready = 1;
      step(); redirect_ready = 0;

      // ERA write colliding with ERTN is dropped
      wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1C000104;
      csr_we = 1; csr_sel = 2; csr_wdata = 32'h1234;
      step(); clr_wb();
      chk("col_era", era_out, 32'h80000200);
      step();
      chk("col_rdpc", redirect_pc, 32'h80000200);
      redirect_ready = 1;
      step(); redirect_ready = 0;
      csr_we = 1; csr_sel = 2; csr_wdata = 32'h1234;
      step(); clr_wb();
      chk("idle_era", era_out, 32'h1234);
      csr_we = 1; csr_sel = 3; csr_wdata = 32'hFFFF;
      step(); clr_wb();
      chk("sel3_era", era_out, 32'h1234);
      chk("sel3_crmd", {crmd_ie, crmd_plv}, 3'b111);

      // Exception with ERTN set: exception wins; CSR write in FLUSH dropped
      wb_valid = 1; wb_ex = 1; wb_ertn = 1; wb_ecode = 6'h8; wb_esubcode = 9'h5; wb_pc = 32'h80000300;
      step(); clr_wb();
      chk("xe_rec", {rec_ex, rec_ertn}, 2'b10);
      chk("xe_rec_esub", rec_esubcode, 9'h5);
      chk("xe_estat_esub", estat_esubcode, 9'h5);
      csr_we = 1; csr_sel = 0; csr_wdata = 32'h7;
      step(); clr_wb();
      chk("fl_csr_drop", {crmd_ie, crmd_plv}, 0);
      chk("xe_rdv", redirect_valid, 1);

      // Reset mid-REDIRECT
      #2 resetn = 0;
      #1;
      chk("mr_rdv", redirect_valid, 0);
      chk("mr_ready", wb_ready, 0);
      chk("mr_era", era_out, 32'h0);
      chk("mr_prmd", {prmd_pie, prmd_pplv}, 0);
      chk("mr_estat", estat_ecode, 0);
      step();
      resetn = 1;
      step();
      chk("mr_post_ready", wb_ready, 1);
      chk("mr_post_flush", flush, 0);
      chk("mr_post_rec", rec_valid, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
